// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes and the channel FSM state encodings
// used by the register bank.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed registers with readback,
// SLVERR on out-of-range decode, and a per-register write-update pulse.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK   = 32'hC,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           arst_n,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  // write response channel
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  // fabric side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_data_width
    $error("axil_reg_bank: DATA_WIDTH must be a multiple of 8 in 8..64");
  end
  if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("axil_reg_bank: NUM_REGS must be in 1..16");
  end

  wr_state_t  r_wr_state;
  rd_state_t  r_rd_state;
  axil_resp_t r_bresp;
  axil_resp_t r_rresp;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]                 r_wr_pulse;
  logic [DATA_WIDTH-1:0]               r_rdata;

  logic [ADDR_WIDTH-1:0] w_aw_word;
  logic [ADDR_WIDTH-1:0] w_ar_word;
  logic [NUM_REGS-1:0]   w_aw_hit;
  logic [NUM_REGS-1:0]   w_ar_hit;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_hs;
  logic                  w_rd_hs;

  // Masked-out address bits are dropped before the word index is formed, so
  // addresses differing only outside ADDR_MASK alias onto the same register.
  assign w_aw_word = (s_axi_awaddr & ADDR_MASK) >> 2;
  assign w_ar_word = (s_axi_araddr & ADDR_MASK) >> 2;

  // NOTE: every always_comb output gets a default before the loop; without it
  // an unmatched index would have to hold its old value and a latch is inferred.
  always_comb begin
    w_aw_hit  = '0;
    w_ar_hit  = '0;
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_aw_hit[i] = (w_aw_word == ADDR_WIDTH'(i));
      w_ar_hit[i] = (w_ar_word == ADDR_WIDTH'(i));
      if (w_ar_hit[i]) begin
        w_rd_data = r_regs[i];
      end
    end
  end

  // AW and W are only ever taken together, and never while a response is owed.
  assign w_wr_hs       = (r_wr_state == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign s_axi_awready = w_wr_hs;
  assign s_axi_wready  = w_wr_hs;
  assign s_axi_bvalid  = (r_wr_state == W_RESP);
  assign s_axi_bresp   = r_bresp;

  assign s_axi_arready = (r_rd_state == R_IDLE);
  assign w_rd_hs       = s_axi_arready && s_axi_arvalid;
  assign s_axi_rvalid  = (r_rd_state == R_RESP);
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  assign reg_out      = r_regs;
  assign reg_wr_pulse = r_wr_pulse;

  // Write response path.
  // NOTE: sequential state is assigned with <= only, so every process sees
  // pre-edge values and the read/write paths can't race each other.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_state <= W_IDLE;
      r_bresp    <= OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: if (w_wr_hs) begin
          r_wr_state <= W_RESP;
          r_bresp    <= (|w_aw_hit) ? OKAY : SLVERR;
        end
        W_RESP: if (s_axi_bready) begin
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Register array and update pulses.
  // NOTE: this is a small flop array, not a RAM macro, so every entry is
  // reset; a true memory would be left unreset and initialised by software.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_regs     <= {NUM_REGS{RESET_VALUE}};
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_wr_hs) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_aw_hit[i]) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (s_axi_wstrb[b]) begin
                r_regs[i][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read path: data captured from pre-edge register contents, so a same-cycle
  // write to the same register is not visible to this read.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_state <= R_IDLE;
      r_rresp    <= OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (w_rd_hs) begin
          r_rd_state <= R_RESP;
          r_rdata    <= w_rd_data;
          r_rresp    <= (|w_ar_hit) ? OKAY : SLVERR;
        end
        R_RESP: if (s_axi_rready) begin
          r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: a 4-register and a 3-register instance
// driven in lockstep from the same AXI stimulus.
module tb_axil_reg_bank;

  logic        aclk = 1'b0;
  logic        arst_n;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] reg_out;
  logic [3:0]   pulse;

  logic         awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]   bresp3, rresp3;
  logic [31:0]  rdata3;
  logic [95:0]  reg_out3;
  logic [2:0]   pulse3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  axil_reg_bank #(.NUM_REGS(4)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(pulse)
  );

  axil_reg_bank #(.NUM_REGS(3)) dut3 (
    .aclk(aclk), .arst_n(arst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready3),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready3),
    .s_axi_bresp(bresp3), .s_axi_bvalid(bvalid3), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready3),
    .s_axi_rdata(rdata3), .s_axi_rresp(rresp3), .s_axi_rvalid(rvalid3), .s_axi_rready(rready),
    .reg_out(reg_out3), .reg_wr_pulse(pulse3)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic put_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic drop_write();
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic put_read(input logic [31:0] a);
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
  endtask

  task automatic drop_read();
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic ack_b();
    @(negedge aclk); bready = 1'b1;
    @(posedge aclk); #1; bready = 1'b0;
  endtask

  task automatic ack_r();
    @(negedge aclk); rready = 1'b1;
    @(posedge aclk); #1; rready = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst bvalid", bvalid, 0);
    check("rst rvalid", rvalid, 0);
    check("rst rdata", rdata, 0);
    check("rst reg_out", reg_out, 0);
    check("rst pulse", pulse, 0);
    @(negedge aclk); arst_n = 1'b1;

    // Full-word write then read of register 1
    put_write(32'h4, 32'hDEADBEEF, 4'hF);
    #1 check("wr1 awready", {awready, wready}, 2'b11);
    drop_write();
    check("wr1 bvalid", bvalid, 1);
    check("wr1 bresp", bresp, 2'b00);
    check("wr1 reg1", reg_out[63:32], 32'hDEADBEEF);
    check("wr1 pulse", pulse, 4'b0010);
    @(posedge aclk); #1;
    check("wr1 pulse clear", pulse, 4'b0000);
    check("wr1 bvalid held", bvalid, 1);
    ack_b();
    check("wr1 bvalid done", bvalid, 0);
    put_read(32'h4);
    #1 check("rd1 arready", arready, 1);
    drop_read();
    check("rd1 rvalid", rvalid, 1);
    check("rd1 rdata", rdata, 32'hDEADBEEF);
    check("rd1 rresp", rresp, 2'b00);
    ack_r();
    check("rd1 rvalid done", rvalid, 0);

    // Partial strobe through an aliased address
    put_write(32'h104, 32'h11223344, 4'b0101);
    drop_write();
    check("alias reg_out", reg_out, {32'h0, 32'h0, 32'hDE22BE44, 32'h0});
    check("alias pulse", pulse, 4'b0010);
    ack_b();

    // Zero strobe: OKAY and a pulse, but no data change
    put_write(32'h0, 32'hFFFFFFFF, 4'b0000);
    drop_write();
    check("nostrb bresp", bresp, 2'b00);
    check("nostrb pulse", pulse, 4'b0001);
    check("nostrb reg0", reg_out[31:0], 32'h0);
    ack_b();

    // Backpressure: second write held off until the cycle after bready
    put_write(32'h8, 32'hA5A5A5A5, 4'hF);
    drop_write();
    put_write(32'hC, 32'h12345678, 4'hF);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp bvalid", bvalid, 1);
      check("bp bresp", bresp, 2'b00);
      check("bp awready", awready, 0);
      @(negedge aclk);
    end
    bready = 1'b1;
    #1 check("bp awready at bready", awready, 0);
    @(posedge aclk); #1; bready = 1'b0;
    check("bp awready after", awready, 1);
    check("bp reg3 before", reg_out[127:96], 32'h0);
    drop_write();
    check("bp bvalid 2nd", bvalid, 1);
    check("bp reg3", reg_out[127:96], 32'h12345678);
    check("bp reg2", reg_out[95:64], 32'hA5A5A5A5);
    ack_b();

    // Out of range on the 3-register instance (index 3)
    put_write(32'hC, 32'hFFFFFFFF, 4'hF);
    drop_write();
    check("oor bresp3", bresp3, 2'b10);
    check("oor pulse3", pulse3, 3'b000);
    check("oor reg_out3", reg_out3, {32'hA5A5A5A5, 32'hDE22BE44, 32'h0});
    check("oor bresp4", bresp, 2'b00);
    check("oor pulse4", pulse, 4'b1000);
    ack_b();
    put_read(32'hC);
    drop_read();
    check("oor rdata3", rdata3, 32'h0);
    check("oor rresp3", rresp3, 2'b10);
    check("oor rdata4", rdata, 32'hFFFFFFFF);
    check("oor rresp4", rresp, 2'b00);
    ack_r();

    // Same-cycle read and write of register 2
    put_write(32'h8, 32'h0, 4'hF);
    araddr = 32'h8; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("conc rdata", rdata, 32'hA5A5A5A5);
    check("conc reg2", reg_out[95:64], 32'h0);
    check("conc valids", {bvalid, rvalid}, 2'b11);
    ack_b();
    ack_r();

    // Reset with both responses pending
    put_write(32'h4, 32'h55AA55AA, 4'hF);
    drop_write();
    put_read(32'h4);
    drop_read();
    check("mid both valid", {bvalid, rvalid}, 2'b11);
    #2 arst_n = 1'b0;
    #1;
    check("mid rst valids", {bvalid, rvalid}, 2'b00);
    check("mid rst reg_out", reg_out, 0);
    check("mid rst reg_out3", reg_out3, 0);
    @(negedge aclk); arst_n = 1'b1;
    bready = 1'b1; rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge aclk); #1;
      check("post rst quiet", {bvalid, rvalid}, 2'b00);
    end
    bready = 1'b0; rready = 1'b0;
    put_read(32'hC);
    drop_read();
    check("post rst rdata", rdata, 32'h0);
    check("post rst rresp", rresp, 2'b00);
    ack_r();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
